// File: rtl/hold_repeat_ctrl.sv
// -----------------------------------------------------------------------------
// hold_repeat_ctrl
//   Button-hold refresh timebase. The raw push-button level is synchronised
//   and debounced. The block then issues single-cycle "increment" strobes:
//   one on the accepted press, one after an initial hold delay, and then
//   auto-repeats. The repeat period halves once enough pulses have been issued
//   in the current press. It sits between the raw button and any counter or
//   display logic that consumes increment strobes.
//
// Ports
//   clk      in   1  system clock
//   rst      in   1  synchronous, active-high reset
//   boton    in   1  raw asynchronous push-button level, 1 = pressed
//   Q        out  1  action strobe, exactly one clk cycle wide
//   held     out  1  high while waiting for the first repeat or repeating
//   fast     out  1  high while rep_cnt >= ACCEL_AFTER
//   rep_cnt  out  8  pulses issued in the current press, saturates at 255
// -----------------------------------------------------------------------------
module hold_repeat_ctrl #(
  parameter int CNT_W           = 25,
  parameter int DEBOUNCE_CYC    = 1_000_000,
  parameter int FIRST_DELAY_CYC = 25_000_000,
  parameter int REPEAT_CYC      = 5_000_000,
  parameter int ACCEL_AFTER     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       boton,
  output logic       Q,
  output logic       held,
  output logic       fast,
  output logic [7:0] rep_cnt
);

  // Every interval must be representable by the shared counter and non-zero.
  localparam longint MAX_CYC = (longint'(1) << CNT_W) - 1;

  generate
    if (DEBOUNCE_CYC <= 0 || longint'(DEBOUNCE_CYC) > MAX_CYC ||
        FIRST_DELAY_CYC <= 0 || longint'(FIRST_DELAY_CYC) > MAX_CYC ||
        REPEAT_CYC <= 0 || longint'(REPEAT_CYC) > MAX_CYC) begin : g_bad_cyc
      $error("hold_repeat_ctrl: every *_CYC must lie in 1 .. 2**CNT_W-1");
    end
  endgenerate

  // Fast period is half the slow one, but never shorter than one cycle.
  localparam int FAST_CYC = (REPEAT_CYC / 2 > 0) ? REPEAT_CYC / 2 : 1;

  localparam logic [CNT_W-1:0] DEB_TERM   = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] FIRST_TERM = CNT_W'(FIRST_DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] SLOW_TERM  = CNT_W'(REPEAT_CYC - 1);
  localparam logic [CNT_W-1:0] FAST_TERM  = CNT_W'(FAST_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    WAIT_FIRST,
    REPEAT,
    DEB_REL
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [1:0]       sync_reg;
  logic             sync;
  logic [CNT_W-1:0] rep_term;

  // Two-flop synchroniser; the FSM only ever looks at the second stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], boton};
    end
  end

  assign sync     = sync_reg[1];
  assign rep_term = fast ? FAST_TERM : SLOW_TERM;

  function automatic logic [7:0] sat_inc(input logic [7:0] n);
    return (n == 8'hFF) ? n : n + 8'd1;
  endfunction

  function automatic logic at_accel(input logic [7:0] n);
    return int'(n) >= ACCEL_AFTER;
  endfunction

  // Counter holds at all-ones rather than wrapping.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  // fast is updated together with rep_cnt so the new period applies to the
  // very gap that follows the pulse reaching ACCEL_AFTER.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      Q         <= 1'b0;
      held      <= 1'b0;
      fast      <= 1'b0;
      rep_cnt   <= 8'd0;
    end else begin
      Q <= 1'b0;
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (sync) begin
            state_reg <= DEB_PRESS;
          end
        end

        DEB_PRESS: begin
          if (!sync) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else if (cnt_reg == DEB_TERM) begin
            Q         <= 1'b1;
            rep_cnt   <= 8'd1;
            fast      <= at_accel(8'd1);
            held      <= 1'b1;
            state_reg <= WAIT_FIRST;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_inc(cnt_reg);
          end
        end

        WAIT_FIRST: begin
          // Release takes priority over a coincident terminal count.
          if (!sync) begin
            held      <= 1'b0;
            state_reg <= DEB_REL;
            cnt_reg   <= '0;
          end else if (cnt_reg == FIRST_TERM) begin
            Q         <= 1'b1;
            rep_cnt   <= sat_inc(rep_cnt);
            fast      <= at_accel(sat_inc(rep_cnt));
            state_reg <= REPEAT;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_inc(cnt_reg);
          end
        end

        REPEAT: begin
          if (!sync) begin
            held      <= 1'b0;
            state_reg <= DEB_REL;
            cnt_reg   <= '0;
          end else if (cnt_reg == rep_term) begin
            Q       <= 1'b1;
            rep_cnt <= sat_inc(rep_cnt);
            fast    <= at_accel(sat_inc(rep_cnt));
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_inc(cnt_reg);
          end
        end

        DEB_REL: begin
          // Any bounce back to pressed restarts the release window.
          if (sync) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DEB_TERM) begin
            rep_cnt   <= 8'd0;
            fast      <= 1'b0;
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_inc(cnt_reg);
          end
        end

        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
          held      <= 1'b0;
          fast      <= 1'b0;
          rep_cnt   <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hold_repeat_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hold_repeat_ctrl
//   Directed bench for hold_repeat_ctrl with small timing parameters
//   (debounce 4, first delay 10, repeat 6, accelerate after 4 pulses).
//   Cycle index i = 0 is the first edge that samples the new boton pattern;
//   outputs are sampled 1 time unit after each edge. With these parameters
//   the press pulse appears at i = 6, then gaps of 10, 6, 6, 3, 3, ...
// -----------------------------------------------------------------------------
module tb_hold_repeat_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       boton;
  logic       Q;
  logic       held;
  logic       fast;
  logic [7:0] rep_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  bit         pat     [1024];
  logic       held_a  [1024];
  logic       fast_a  [1024];
  logic [7:0] rc_a    [1024];
  int         pulses  [$];

  hold_repeat_ctrl #(
    .CNT_W          (25),
    .DEBOUNCE_CYC   (4),
    .FIRST_DELAY_CYC(10),
    .REPEAT_CYC     (6),
    .ACCEL_AFTER    (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .boton  (boton),
    .Q      (Q),
    .held   (held),
    .fast   (fast),
    .rep_cnt(rep_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end else begin
      $display("ok   %s: %0d", tag, actual);
    end
  endtask

  task automatic set_pat(input int lo, input int hi, input bit v);
    for (int i = lo; i < hi; i++) pat[i] = v;
  endtask

  // Drive pat[0..n-1], one value per edge, recording outputs and Q pulse cycles.
  task automatic run(input int n);
    pulses.delete();
    for (int i = 0; i < n; i++) begin
      boton = pat[i];
      @(posedge clk);
      #1;
      held_a[i] = held;
      fast_a[i] = fast;
      rc_a[i]   = rep_cnt;
      if (Q) pulses.push_back(i);
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    boton = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic int pulse_at(input int k);
    return (k < pulses.size()) ? pulses[k] : -1;
  endfunction

  initial begin
    int exp1 [15] = '{6, 16, 22, 28, 31, 34, 37, 40, 43, 46, 49, 52, 55, 58, 61};

    rst   = 1'b1;
    boton = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_Q", int'(Q), 0);
    check_eq("reset_held", int'(held), 0);
    check_eq("reset_fast", int'(fast), 0);
    check_eq("reset_rep_cnt", int'(rep_cnt), 0);
    rst = 1'b0;

    // 1: long press then release
    set_pat(0, 60, 1'b1);
    set_pat(60, 70, 1'b0);
    run(70);
    check_eq("t1_pulse_count", pulses.size(), 15);
    for (int k = 0; k < 15; k++) begin
      check_eq($sformatf("t1_pulse%0d_cycle", k + 1), pulse_at(k), exp1[k]);
    end
    check_eq("t1_held_before_p1", int'(held_a[5]), 0);
    check_eq("t1_held_at_p1", int'(held_a[6]), 1);
    check_eq("t1_rep_cnt_at_p1", int'(rc_a[6]), 1);
    check_eq("t1_fast_before_p4", int'(fast_a[27]), 0);
    check_eq("t1_fast_at_p4", int'(fast_a[28]), 1);
    check_eq("t1_rep_cnt_at_p4", int'(rc_a[28]), 4);
    check_eq("t1_rep_cnt_last", int'(rc_a[61]), 15);
    check_eq("t1_held_before_rel", int'(held_a[61]), 1);
    check_eq("t1_held_after_rel", int'(held_a[62]), 0);
    check_eq("t1_rep_cnt_in_deb_rel", int'(rc_a[65]), 15);
    check_eq("t1_rep_cnt_idle", int'(rc_a[66]), 0);
    check_eq("t1_fast_idle", int'(fast_a[66]), 0);

    // 2: 3-cycle glitch, then a clean press proves a fresh debounce from IDLE
    do_reset();
    set_pat(0, 3, 1'b1);
    set_pat(3, 20, 1'b0);
    run(20);
    check_eq("t2_glitch_pulses", pulses.size(), 0);
    check_eq("t2_rep_cnt", int'(rc_a[19]), 0);
    check_eq("t2_held", int'(held_a[19]), 0);
    set_pat(0, 10, 1'b1);
    run(10);
    check_eq("t2_next_press_pulses", pulses.size(), 1);
    check_eq("t2_next_press_cycle", pulse_at(0), 6);

    // 3: short press with release bounce 1-0-1-0
    do_reset();
    set_pat(0, 8, 1'b1);
    set_pat(8, 30, 1'b0);
    pat[9]  = 1'b1;
    pat[11] = 1'b1;
    run(30);
    check_eq("t3_pulse_count", pulses.size(), 1);
    check_eq("t3_pulse_cycle", pulse_at(0), 6);
    check_eq("t3_held_pressed", int'(held_a[9]), 1);
    check_eq("t3_held_released", int'(held_a[10]), 0);
    check_eq("t3_rep_cnt_bounce", int'(rc_a[16]), 1);
    check_eq("t3_rep_cnt_idle", int'(rc_a[17]), 0);

    // 4: reset on the edge that would issue pulse 5, button still pressed
    do_reset();
    set_pat(0, 31, 1'b1);
    run(31);
    check_eq("t4_pulses_before_rst", pulses.size(), 4);
    check_eq("t4_fast_before_rst", int'(fast_a[30]), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("t4_rst_Q", int'(Q), 0);
    check_eq("t4_rst_held", int'(held), 0);
    check_eq("t4_rst_fast", int'(fast), 0);
    check_eq("t4_rst_rep_cnt", int'(rep_cnt), 0);
    rst = 1'b0;
    set_pat(0, 10, 1'b1);
    run(10);
    check_eq("t4_repress_pulses", pulses.size(), 1);
    check_eq("t4_repress_cycle", pulse_at(0), 6);
    check_eq("t4_held_before", int'(held_a[5]), 0);

    // 5: release lands on the repeat terminal-count cycle (would pulse at 22)
    do_reset();
    set_pat(0, 20, 1'b1);
    set_pat(20, 30, 1'b0);
    run(30);
    check_eq("t5_pulse_count", pulses.size(), 2);
    check_eq("t5_pulse2_cycle", pulse_at(1), 16);
    check_eq("t5_held_before", int'(held_a[21]), 1);
    check_eq("t5_held_after", int'(held_a[22]), 0);
    check_eq("t5_rep_cnt_deb_rel", int'(rc_a[25]), 2);
    check_eq("t5_rep_cnt_idle", int'(rc_a[26]), 0);

    // 6: hold through more than 300 pulses
    do_reset();
    set_pat(0, 1000, 1'b1);
    run(1000);
    check_eq("t6_pulse_count", pulses.size(), 327);
    check_eq("t6_pulse300_cycle", pulse_at(299), 916);
    check_eq("t6_rep_cnt_254", int'(rc_a[780]), 254);
    check_eq("t6_rep_cnt_255", int'(rc_a[781]), 255);
    check_eq("t6_rep_cnt_sat", int'(rc_a[999]), 255);
    check_eq("t6_last_gap", pulse_at(326) - pulse_at(325), 3);
    check_eq("t6_fast", int'(fast_a[999]), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
